// File: rtl/adv7513_i2c_target.sv
// I2C target emulating the ADV7513 register map: 256x8 regs, sub-address pointer, burst R/W.
// Latency: pin edge to detection 2+FILT_LEN clk; sda changes the cycle after filtered scl fall.
// Backpressure: none; no clock stretching, scl always released, sda only pulled low or released.
module adv7513_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter logic [7:0] CHIP_REV = 8'h13,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t          state;
  logic [7:0]      regs [256];
  logic [7:0]      shreg;
  logic [7:0]      ptr;
  logic [7:0]      ptr_inc;
  logic [3:0]      bit_cnt;
  logic            rw;
  logic            mack;
  logic            sda_oe;
  logic [1:0]      scl_sync;
  logic [1:0]      sda_sync;
  logic            scl_f;
  logic            sda_f;
  logic            scl_q;
  logic            sda_q;
  logic [CW-1:0]   scl_cnt;
  logic [CW-1:0]   sda_cnt;
  logic            scl_rise;
  logic            scl_fall;
  logic            start_det;
  logic            stop_det;
  logic            rx_bit;
  logic            rx_done;
  logic [7:0]      rd_cur;
  logic [7:0]      rd_next;

  // Open-drain: only ever pull sda low; scl is never driven.
  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = 1'bz;

  // Two-flop synchronizers; idle bus level is high so reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

  // Stability filter: a new level must persist FILT_LEN cycles before it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILT_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILT_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_bit    = scl_rise && (bit_cnt != 4'd8);
  assign rx_done   = scl_fall && (bit_cnt == 4'd8);
  assign ptr_inc   = ptr + 8'd1;

  // Read view of the register file: sub-address 0x00 is the fixed chip revision.
  always_comb begin
    rd_cur  = (ptr == 8'h00) ? CHIP_REV : regs[ptr];
    rd_next = (ptr_inc == 8'h00) ? CHIP_REV : regs[ptr_inc];
  end

  // Protocol FSM; START/STOP override every state and drop any partial byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= 8'h00;
      ptr     <= 8'h00;
      bit_cnt <= 4'd0;
      rw      <= 1'b0;
      mack    <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_det) begin
        state   <= ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        if ((state == ADDR || state == SUB || state == WDATA) && rx_bit) begin
          shreg   <= {shreg[6:0], sda_f};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ADDR: begin
            if (rx_done) begin
              bit_cnt <= 4'd0;
              if (shreg[7:1] == DEV_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shreg[0];
                state  <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shreg  <= rd_cur;
                sda_oe <= ~rd_cur[7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= SUB;
              end
            end
          end
          SUB: begin
            if (rx_done) begin
              bit_cnt <= 4'd0;
              ptr     <= shreg;
              sda_oe  <= 1'b1;
              state   <= SUB_ACK;
            end
          end
          SUB_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (rx_done) begin
              bit_cnt <= 4'd0;
              sda_oe  <= 1'b1;
              state   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              if (ptr != 8'h00) regs[ptr] <= shreg;
              wr_stb  <= 1'b1;
              wr_addr <= ptr;
              wr_data <= shreg;
              ptr     <= ptr_inc;
              state   <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RDATA_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              mack <= sda_f;
            end else if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (!mack) begin
                ptr    <= ptr_inc;
                shreg  <= rd_next;
                sda_oe <= ~rd_next[7];
                state  <= RDATA;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Debug read port; same-cycle bus writes show up one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dbg_data <= 8'h00;
    else       dbg_data <= (dbg_addr == 8'h00) ? CHIP_REV : regs[dbg_addr];
  end

endmodule
